reg_bank_wb: RTL
================

// Module: reg_bank_wb
// PURPOSE
//  General-purpose register file of the multicycle MIPS datapath; direct consumer of the
//  regDst write-address mux (wr_addr) and the memToReg write-data mux (wr_data).
//  Two registered read ports feed the A/B operand registers. Write port commits at the clock edge.
//  A debug dump engine streams all 32 registers, one per cycle, for bench/scoreboard checking.
// PARAMETERS
//  DATA_W    32   register width, in bits
//  SP_INIT   227  reset value of $29 (stack pointer); all other registers reset to 0
//  FORWARD   1    1: a read of the register written this cycle returns wr_data; 0: returns old value
// PORTS
//  clk         in   1       rising-edge clock
//  reset_n     in   1       asynchronous reset, active low
//  rd_addr_a   in   5       read port A address (rs)
//  rd_addr_b   in   5       read port B address (rt)
//  rd_data_a   out  DATA_W  registered read data A
//  rd_data_b   out  DATA_W  registered read data B
//  wr_en       in   1       write enable (RegWrite)
//  wr_addr     in   5       write address from regDst mux
//  wr_data     in   DATA_W  write data
//  dump_req    in   1       1-cycle pulse: start register dump
//  dump_busy   out  1       high while dump in progress
//  dump_valid  out  1       dump_idx/dump_data valid this cycle
//  dump_idx    out  5       register index being dumped
//  dump_data   out  DATA_W  value of register dump_idx
// BEHAVIOUR
//  Reset (reset_n=0, async): regs[0..31]=0 except regs[29]=SP_INIT; rd_data_a/b=0;
//   dump FSM -> IDLE; dump_busy=0, dump_valid=0, dump_idx=0, dump_data=0. Mid-dump reset aborts dump.
//  Write: at posedge clk, if wr_en && wr_addr!=0, regs[wr_addr]<=wr_data. Writes to $0 are dropped;
//   regs[0] reads 0 always.
//  Read: at every posedge clk, rd_data_x <= value of regs[rd_addr_x] (1-cycle latency, no enable).
//   Same-cycle write to rd_addr_x (wr_en, addr!=0): FORWARD=1 -> wr_data; FORWARD=0 -> pre-write value.
//   rd_addr_x=0 always yields 0, even when wr_addr=0 with wr_en=1.
//  Dump FSM states: IDLE, RUN.
//   IDLE: dump_req=1 -> RUN, counter<=0. dump_valid=0, dump_busy=0.
//   RUN: each cycle dump_valid=1, dump_idx=counter, dump_data=regs[counter] as sampled at the edge
//    that entered this cycle (registered, FORWARD rule applies to a concurrent write);
//    counter increments; after idx 31 is presented -> IDLE next cycle.
//   First valid beat is the cycle after dump_req is sampled; 32 consecutive beats, idx 0..31, no gaps.
//   dump_busy=1 for exactly those 32 cycles. dump_req while busy is ignored (no restart, no queue).
//   Dump never stalls or blocks the write/read ports; counter is 5-bit, wrap 31->0 ends the dump.
// TESTING
//  Reset: release reset_n, read all via dump -> idx 29 = 227, all others 0; rd_data_a/b = 0.
//  Write/read: wr_en=1, wr_addr=8, wr_data=32'hDEADBEEF; next cycle rd_addr_a=8 -> rd_data_a=DEADBEEF a cycle later.
//  $0 guard: wr_en=1, wr_addr=0, wr_data=5; rd_addr_a=0 -> rd_data_a=0; dump idx0 = 0.
//  Bypass: same cycle wr_addr=rd_addr_b=9, wr_data=7, old $9=3 -> rd_data_b=7 (FORWARD=1) / 3 (FORWARD=0).
//  Dump + concurrent write: dump_req, write $31=32'h1234 during beat idx 5 -> idx 31 beat shows 1234;
//   dump_req repeated mid-dump ignored; exactly 32 valid beats.
//  Async reset mid-dump at idx 12 -> dump_busy/valid drop immediately, $29=227, $8=0.

Source files
------------

// File: rtl/reg_bank_wb.sv
// Register file for the multicycle MIPS datapath.
// It has two registered read ports and one write port, plus a debug engine that dumps all 32 registers.
module reg_bank_wb #(
  parameter int DATA_W  = 32,
  parameter int SP_INIT = 227,
  parameter int FORWARD = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [4:0]        dump_idx,
  output logic [DATA_W-1:0] dump_data
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [32];
  logic [4:0]        cnt, cnt_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              wr_hit;

  assign wr_hit = wr_en && (wr_addr != 5'd0);

  // Value seen by a read sampled at this edge, honouring the bypass mode
  function automatic logic [DATA_W-1:0] rdval(input logic [4:0] a);
    logic [DATA_W-1:0] v;
    v = regs[a];
    if (a == 5'd0)
      v = '0;
    else if ((FORWARD != 0) && wr_hit && (wr_addr == a))
      v = wr_data;
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 29) ? DATA_W'(SP_INIT) : '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= rdval(rd_addr_a);
      rd_data_b <= rdval(rd_addr_b);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dump_data <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dump_data <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (dump_req)
          state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = cnt + 5'd1;
        if (cnt == 5'd31)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    data_nxt = (state_nxt == RUN) ? rdval(cnt_nxt) : '0;
  end

  always_comb begin
    dump_busy  = (state == RUN);
    dump_valid = (state == RUN);
    dump_idx   = cnt;
  end

endmodule
